// File: rtl/eth_ram_frame_reader.sv
// Read-side frame engine for the Ethernet frame-buffer RAM: converts (addr, len) descriptors into
// RAM port-B reads and a valid/ready byte stream, hiding the RAM latency behind a credit-limited skid FIFO.
module eth_ram_frame_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH:0]   req_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  done,
    output logic                  busy
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    state_t                  state_r;
    logic                    idle_r;
    logic                    rden_r;
    logic                    done_r;
    logic                    busy_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LEN_W-1:0]        remain_r;
    logic [RD_LATENCY-1:0]   vld_pipe_r;
    logic [RD_LATENCY-1:0]   last_pipe_r;
    logic [DATA_WIDTH:0]     fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        fifo_count_r;

    logic                    accept_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    issue_s;
    logic [LEN_W-1:0]        len_clamped_s;
    logic [CNT_W-1:0]        inflight_s;
    logic [SUM_W-1:0]        occupancy_s;
    logic [DATA_WIDTH:0]     fifo_head_s;

    // Count reads on the RAM bus or still travelling through the read-latency pipe.
    always_comb begin
        inflight_s = CNT_W'(rden_r);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(vld_pipe_r[i]);
        end
    end

    // req_ready is forced low while rst is held so nothing is accepted during reset.
    assign req_ready     = idle_r & ~rst;
    assign accept_s      = req_valid & req_ready;
    assign len_clamped_s = (req_len > MAX_LEN) ? MAX_LEN : req_len;

    assign fifo_head_s = fifo_mem_r[rd_ptr_r];
    assign m_valid     = (fifo_count_r != {CNT_W{1'b0}});
    assign m_data      = m_valid ? fifo_head_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
    assign m_last      = m_valid & fifo_head_s[DATA_WIDTH];
    assign pop_s       = m_valid & m_ready;
    assign push_s      = vld_pipe_r[RD_LATENCY-1];

    // Credit: every issued read owns a FIFO slot; a slot freed by this cycle's pop is reusable.
    assign occupancy_s = SUM_W'(fifo_count_r) + SUM_W'(inflight_s) - SUM_W'(pop_s);
    assign issue_s     = (state_r == ST_READ) && (remain_r != {LEN_W{1'b0}}) &&
                         (occupancy_s < SUM_W'(FIFO_DEPTH));

    assign ram_addr = addr_r;
    assign ram_rden = rden_r;
    assign done     = done_r;
    assign busy     = busy_r;

    // Frame control FSM with registered RAM-port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idle_r   <= 1'b1;
            rden_r   <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            remain_r <= {LEN_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        idle_r <= 1'b0;
                        busy_r <= 1'b1;
                        if (len_clamped_s != {LEN_W{1'b0}}) begin
                            state_r  <= ST_READ;
                            rden_r   <= 1'b1;
                            addr_r   <= req_addr;
                            remain_r <= len_clamped_s - LEN_W'(1);
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        rden_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    // remain_r reaches zero on the edge that issues the final read.
                    if (remain_r == {LEN_W{1'b0}}) begin
                        state_r <= ST_DRAIN;
                        rden_r  <= 1'b0;
                    end else if (issue_s) begin
                        rden_r   <= 1'b1;
                        addr_r   <= addr_r + ADDR_WIDTH'(1);
                        remain_r <= remain_r - LEN_W'(1);
                    end else begin
                        rden_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    rden_r <= 1'b0;
                    if (pop_s && m_last) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    idle_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    rden_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idle_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    rden_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return tracking and FIFO pointers; reset drops any RAM data still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r   <= {RD_LATENCY{1'b0}};
            last_pipe_r  <= {RD_LATENCY{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
        end else begin
            vld_pipe_r[0]  <= rden_r;
            last_pipe_r[0] <= rden_r & (remain_r == {LEN_W{1'b0}});
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            fifo_count_r <= fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO storage: RAM byte tagged with its end-of-frame flag.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {last_pipe_r[RD_LATENCY-1], ram_dout};
        end
    end

endmodule
